// File: rtl/dffn_bank_pkg.sv
// dffn_bank_pkg
// Shared definitions for the falling-edge pipeline bank:
//   - mode_e      : operating mode decoded from {SE,E} (scan / load / hold)
//   - decode_mode : maps {SE,E} to a mode; unknown inputs map to MODE_BAD so
//                   the registers go pessimistically unknown in simulation
//   - fill_w      : width of the fill counter that must count 0..DEPTH
package dffn_bank_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SCAN = 2'b10,
        MODE_BAD  = 2'b11
    } mode_e;

    // SE dominates E; any X/Z on either input falls through to MODE_BAD.
    function automatic mode_e decode_mode(input logic se, input logic e);
        mode_e m;
        case ({se, e})
            2'b00:        m = MODE_HOLD;
            2'b01:        m = MODE_LOAD;
            2'b10, 2'b11: m = MODE_SCAN;
            default:      m = MODE_BAD;
        endcase
        return m;
    endfunction

    // Counter must hold the value DEPTH itself, hence DEPTH+1 codes.
    function automatic int fill_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffn_bank_stage.sv
// dffn_bank_stage
// One WIDTH-bit row of falling-edge flops with per-bit reset value INIT.
// Ports:
//   CLKN  in   falling-edge clock
//   RN    in   asynchronous active-low reset (Q <= INIT)
//   MODE  in   decoded operating mode (hold / load / scan)
//   D     in   parallel load data
//   SI    in   serial input entering bit 0 during scan
//   Q     out  row contents
//   SO    out  bit WIDTH-1, feeds the next row's SI in the scan chain
module dffn_bank_stage
    import dffn_bank_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
    input  logic             CLKN,
    input  logic             RN,
    input  mode_e            MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] shift_s;

    // A single-bit row has no internal shift path; the serial input is the whole next value.
    if (WIDTH == 1) begin : g_shift_one
        assign shift_s = SI;
    end else begin : g_shift_many
        assign shift_s = {q_r[WIDTH-2:0], SI};
    end

    // Row register: reset to INIT, then hold, load or shift on each falling edge.
    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            q_r <= INIT;
        end else begin
            case (MODE)
                MODE_HOLD: q_r <= q_r;
                MODE_LOAD: q_r <= D;
                MODE_SCAN: q_r <= shift_s;
                default:   q_r <= {WIDTH{1'bx}};
            endcase
        end
    end

    assign Q  = q_r;
    assign SO = q_r[WIDTH-1];

endmodule

// File: rtl/dffn_pipe_bank.sv
// dffn_pipe_bank
// DEPTH-stage falling-edge pipeline of WIDTH-bit rows, each bit reset to INIT,
// with a load enable, a serial scan chain through every bit, and a valid flag
// that rises once DEPTH genuine loads have happened since reset or scan.
// Ports:
//   CLKN  in   clock, all updates on the falling edge
//   RN    in   asynchronous active-low reset
//   E     in   load/advance enable
//   SE    in   scan enable, overrides E
//   SI    in   scan serial input (enters stage 0 bit 0)
//   D     in   parallel data into stage 0
//   Q     out  stage DEPTH-1 contents
//   SO    out  stage DEPTH-1 bit WIDTH-1 (end of the scan chain)
//   VLD   out  fill counter has reached DEPTH
module dffn_pipe_bank
    import dffn_bank_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
    input  logic             CLKN,
    input  logic             RN,
    input  logic             E,
    input  logic             SE,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             VLD
);

    localparam int FILL_W = fill_w(DEPTH);
    typedef logic [FILL_W-1:0] fill_t;
    localparam fill_t FILL_MAX = fill_t'(DEPTH);
    localparam fill_t FILL_ONE = fill_t'(1'b1);

    mode_e            mode_s;
    logic [WIDTH-1:0] stage_q_s  [DEPTH];
    logic             stage_so_s [DEPTH];
    fill_t            fill_r;
    fill_t            fill_inc_s;
    logic             vld_r;

    // Mode decode shared by every row and the fill counter.
    always_comb begin
        mode_s = decode_mode(SE, E);
    end

    // Stage 0 takes the external inputs; every later stage chains off its predecessor.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_s;
        logic             si_s;

        if (k == 0) begin : g_head
            assign d_s  = D;
            assign si_s = SI;
        end else begin : g_link
            assign d_s  = stage_q_s[k-1];
            assign si_s = stage_so_s[k-1];
        end

        dffn_bank_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .CLKN (CLKN),
            .RN   (RN),
            .MODE (mode_s),
            .D    (d_s),
            .SI   (si_s),
            .Q    (stage_q_s[k]),
            .SO   (stage_so_s[k])
        );
    end

    // Incremented fill value, only used when not yet saturated.
    always_comb begin
        fill_inc_s = fill_r + FILL_ONE;
    end

    // Fill counter and valid flag: count loads up to DEPTH, cleared by scan or reset.
    // VLD is kept as its own flop so it is a clean registered output.
    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            fill_r <= {FILL_W{1'b0}};
            vld_r  <= 1'b0;
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    fill_r <= fill_r;
                    vld_r  <= vld_r;
                end
                MODE_LOAD: begin
                    if (fill_r != FILL_MAX) begin
                        fill_r <= fill_inc_s;
                        vld_r  <= (fill_inc_s == FILL_MAX);
                    end else begin
                        fill_r <= fill_r;
                        vld_r  <= 1'b1;
                    end
                end
                MODE_SCAN: begin
                    fill_r <= {FILL_W{1'b0}};
                    vld_r  <= 1'b0;
                end
                default: begin
                    fill_r <= {FILL_W{1'bx}};
                    vld_r  <= 1'bx;
                end
            endcase
        end
    end

    assign Q   = stage_q_s[DEPTH-1];
    assign SO  = stage_so_s[DEPTH-1];
    assign VLD = vld_r;

endmodule

// File: tb/tb_dffn_pipe_bank.sv
// Testbench for dffn_pipe_bank (WIDTH=4, DEPTH=2, INIT=4'b1010).
// The reference model treats the whole bank as one WIDTH*DEPTH-bit word:
// a load shifts it left by WIDTH with D entering at the bottom, a scan shifts
// it left by one with SI entering at the bottom; Q is the top WIDTH bits.
module tb_dffn_pipe_bank;

    localparam int               WIDTH = 4;
    localparam int               DEPTH = 2;
    localparam logic [WIDTH-1:0] INIT  = 4'b1010;
    localparam int               CW    = WIDTH * DEPTH;

    logic             CLKN;
    logic             RN;
    logic             E;
    logic             SE;
    logic             SI;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             VLD;

    int total;
    int bad;

    logic [CW-1:0] m_chain;
    int            m_fill;

    dffn_pipe_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INIT)
    ) dut (
        .CLKN (CLKN),
        .RN   (RN),
        .E    (E),
        .SE   (SE),
        .SI   (SI),
        .D    (D),
        .Q    (Q),
        .SO   (SO),
        .VLD  (VLD)
    );

    task automatic model_reset();
        m_chain = {DEPTH{INIT}};
        m_fill  = 0;
    endtask

    task automatic model_edge(input logic se, input logic e, input logic si,
                              input logic [WIDTH-1:0] d);
        if (se) begin
            m_chain = (m_chain << 1) | CW'(si);
            m_fill  = 0;
        end else if (e) begin
            m_chain = (m_chain << WIDTH) | CW'(d);
            m_fill  = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
        end
    endtask

    function automatic logic [WIDTH-1:0] m_q();
        return m_chain[CW-1 -: WIDTH];
    endfunction

    // Rising edge, then sample point 1 unit later.
    task automatic rise();
        #4;
        CLKN = 1'b1;
        #1;
    endtask

    // Falling (active) edge, then sample point 1 unit later.
    task automatic fall();
        #4;
        CLKN = 1'b0;
        #1;
    endtask

    task automatic edge_op(input logic se, input logic e, input logic si,
                           input logic [WIDTH-1:0] d);
        rise();
        SE = se; E = e; SI = si; D = d;
        fall();
        model_edge(se, e, si, d);
    endtask

    task automatic test_reset();
        CLKN = 1'b1; RN = 1'b1; E = 1'b0; SE = 1'b0; SI = 1'b0; D = 4'h0;
        #3;
        RN = 1'b0;
        #1;
        model_reset();
        total++; if (Q !== INIT) begin bad++; $display("FAIL reset_q: got %h want %h", Q, INIT); end
        total++; if (SO !== INIT[WIDTH-1]) begin bad++; $display("FAIL reset_so: got %b want %b", SO, INIT[WIDTH-1]); end
        total++; if (VLD !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", VLD); end
        #2;
        RN = 1'b1;
    endtask

    task automatic test_load();
        edge_op(1'b0, 1'b1, 1'b0, 4'h3);
        total++; if (VLD !== 1'b0) begin bad++; $display("FAIL load1_vld: got %b want 0", VLD); end
        total++; if (Q !== m_q()) begin bad++; $display("FAIL load1_q: got %h want %h", Q, m_q()); end
        edge_op(1'b0, 1'b1, 1'b0, 4'hC);
        total++; if (Q !== 4'h3) begin bad++; $display("FAIL load2_q: got %h want 3", Q); end
        total++; if (VLD !== 1'b1) begin bad++; $display("FAIL load2_vld: got %b want 1", VLD); end
        edge_op(1'b0, 1'b1, 1'b0, 4'h6);
        total++; if (Q !== 4'hC) begin bad++; $display("FAIL load3_q: got %h want c", Q); end
        total++; if (Q !== m_q()) begin bad++; $display("FAIL load3_model_q: got %h want %h", Q, m_q()); end
    endtask

    task automatic test_hold();
        for (int j = 0; j < 3; j++) begin
            logic [WIDTH-1:0] dv;
            dv = WIDTH'($urandom);
            rise();
            SE = 1'b0; E = 1'b0; D = dv;
            total++; if (Q !== m_q()) begin bad++; $display("FAIL hold_rise_q: got %h want %h", Q, m_q()); end
            fall();
            model_edge(1'b0, 1'b0, 1'b0, dv);
            total++; if (Q !== m_q()) begin bad++; $display("FAIL hold_q: got %h want %h", Q, m_q()); end
            total++; if (VLD !== (m_fill == DEPTH)) begin bad++; $display("FAIL hold_vld: got %b want %b", VLD, (m_fill == DEPTH)); end
        end
    endtask

    task automatic test_scan();
        edge_op(1'b0, 1'b1, 1'b0, 4'h0);
        edge_op(1'b0, 1'b1, 1'b0, 4'h0);
        for (int j = 0; j < CW; j++) begin
            edge_op(1'b1, 1'b1, (j == 0), WIDTH'($urandom));
            total++; if (SO !== (j == CW - 1)) begin bad++; $display("FAIL scan_so[%0d]: got %b want %b", j, SO, (j == CW - 1)); end
            total++; if (VLD !== 1'b0) begin bad++; $display("FAIL scan_vld[%0d]: got %b want 0", j, VLD); end
            total++; if (Q !== m_q()) begin bad++; $display("FAIL scan_q[%0d]: got %h want %h", j, Q, m_q()); end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 60; j++) begin
            logic se;
            se = ($urandom_range(0, 4) == 0);
            edge_op(se, 1'($urandom), 1'($urandom), WIDTH'($urandom));
            total++; if (Q !== m_q()) begin bad++; $display("FAIL rand_q[%0d]: got %h want %h", j, Q, m_q()); end
            total++; if (SO !== m_chain[CW-1]) begin bad++; $display("FAIL rand_so[%0d]: got %b want %b", j, SO, m_chain[CW-1]); end
            total++; if (VLD !== (m_fill == DEPTH)) begin bad++; $display("FAIL rand_vld[%0d]: got %b want %b", j, VLD, (m_fill == DEPTH)); end
        end
    endtask

    task automatic test_race();
        rise();
        RN = 1'b0;
        #1;
        model_reset();
        SE = 1'b0; E = 1'b1; D = 4'h5;
        #3;
        CLKN = 1'b0;
        #0;
        RN = 1'b1;
        #1;
        total++; if (Q !== INIT) begin bad++; $display("FAIL race_q: got %h want %h", Q, INIT); end
        total++; if (VLD !== 1'b0) begin bad++; $display("FAIL race_vld: got %b want 0", VLD); end
        edge_op(1'b0, 1'b1, 1'b0, 4'h5);
        total++; if (Q !== m_q()) begin bad++; $display("FAIL race_next_q: got %h want %h", Q, m_q()); end
        total++; if (VLD !== 1'b0) begin bad++; $display("FAIL race_next_vld: got %b want 0", VLD); end
        edge_op(1'b0, 1'b1, 1'b0, WIDTH'($urandom));
        total++; if (Q !== 4'h5) begin bad++; $display("FAIL race_second_q: got %h want 5", Q); end
        total++; if (VLD !== 1'b1) begin bad++; $display("FAIL race_second_vld: got %b want 1", VLD); end
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] d0;
        rise();
        #2;
        RN = 1'b0;
        #1;
        model_reset();
        total++; if (Q !== INIT) begin bad++; $display("FAIL midrst_q: got %h want %h", Q, INIT); end
        total++; if (VLD !== 1'b0) begin bad++; $display("FAIL midrst_vld: got %b want 0", VLD); end
        RN = 1'b1;
        d0 = WIDTH'($urandom);
        SE = 1'b0; E = 1'b1; D = d0;
        fall();
        model_edge(1'b0, 1'b1, 1'b0, d0);
        total++; if (VLD !== 1'b0) begin bad++; $display("FAIL midrst_load1_vld: got %b want 0", VLD); end
        edge_op(1'b0, 1'b1, 1'b0, WIDTH'($urandom));
        total++; if (VLD !== 1'b1) begin bad++; $display("FAIL midrst_load2_vld: got %b want 1", VLD); end
        total++; if (Q !== d0) begin bad++; $display("FAIL midrst_load2_q: got %h want %h", Q, d0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load();
        test_hold();
        test_scan();
        test_random();
        test_race();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
